gin_source: RTL and testbench
=============================

GIN_SOURCE -- requirements
Module: gin_source

Interface
REQ-001 SHALL have parameter ID_LEN, default 4: width of the row and column tags.
REQ-002 SHALL have parameter VALUE_LEN, default 32: payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of packet entries; must be a power of 2 and ≥2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream packet handshake.
REQ-007 SHALL have port in_row_tag, input, ID_LEN: destination row tag.
REQ-008 SHALL have port in_col_tag, input, ID_LEN: destination column tag.
REQ-009 SHALL have port in_value, input, VALUE_LEN: payload.
REQ-010 SHALL have port flush, input, 1: discard all queued packets.
REQ-011 SHALL have port row_tag, output, ID_LEN: row tag broadcast to the GIN Y-bus controllers.
REQ-012 SHALL have port col_tag, output, ID_LEN: column tag broadcast to the X-bus controllers.
REQ-013 SHALL have port enable_out, output, 1: bus enable to the controllers.
REQ-014 SHALL have port value_out, output, VALUE_LEN: payload to the controllers.
REQ-015 SHALL have port ready_in, input, 1: aggregated ready returned from the Y-bus controllers.
REQ-016 SHALL have port empty, output, 1: high when the FIFO holds no packets.

Function
REQ-017 SHALL store packets as {row_tag, col_tag, value} in a circular FIFO with wrapping read and write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-018 SHALL drive in_ready = (count != FIFO_DEPTH) & ~flush & (state != DRAIN); in_ready SHALL have no combinational dependence on ready_in.
REQ-019 SHALL treat a push as in_valid & in_ready; a push writes the entry at the write pointer, then increments the pointer modulo FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-021 SHALL transition IDLE -> ISSUE on the cycle after count becomes nonzero; a packet pushed at edge N SHALL drive enable_out at cycle N+1.
REQ-022 SHALL drive enable_out = (state == ISSUE) & (count != 0).
REQ-023 SHALL drive row_tag, col_tag and value_out from the FIFO head while enable_out is high; when enable_out is low, value_out SHALL be 0 and the tags SHALL hold their last values.
REQ-024 SHALL treat a pop as enable_out & ready_in in the same cycle; a pop advances the read pointer modulo FIFO_DEPTH.
REQ-025 SHALL hold the head packet stable on the bus while enable_out & ~ready_in (stall).
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged; this is permitted even when count == FIFO_DEPTH-1.
REQ-027 SHALL return ISSUE -> IDLE when a pop leaves count == 0 and there is no push in the same cycle.
REQ-028 SHALL, on flush high in any state, enter DRAIN, force enable_out low, and ignore ready_in.
REQ-029 SHALL, in DRAIN, clear count and both pointers at the next edge, then go to IDLE; any push presented in the flush cycle is discarded.
REQ-030 SHALL drive empty = (count == 0).

Reset
REQ-031 SHALL, on an edge with rst == 0, set state = IDLE, clear both pointers and count, and set the tag registers to 0.
REQ-032 SHALL, from reset, hold enable_out = 0, value_out = 0, row_tag = col_tag = 0, empty = 1 and in_ready = 1 in the first cycle after rst is released.
REQ-033 SHALL let reset asserted mid-transfer drop all queued packets, with no bus enable on the following cycle.
REQ-034 SHALL not require reset for FIFO storage contents.

Configuration
REQ-035 SHALL, with GIN_SOURCE_STATS_EN defined, add output pkt_sent (32 bits), a saturating count of pops, cleared by reset but not by flush.
REQ-036 SHALL add output stall_cycles (32 bits), a saturating count of cycles with enable_out & ~ready_in.
REQ-037 SHALL, without GIN_SOURCE_STATS_EN, omit both ports and both counters entirely, with identical remaining behaviour.

Verification
REQ-038 SHALL check: push {row=2, col=5, value=0xDEADBEEF} with ready_in=1 -> enable_out=1 for exactly one cycle, one cycle after the push, with row_tag=2, col_tag=5, value_out=0xDEADBEEF, then empty=1.
REQ-039 SHALL check: push 4 packets with ready_in=0 -> in_ready=0 after the 4th push and the head is held stable; then ready_in=1 -> 4 pops in 4 consecutive cycles in FIFO order.
REQ-040 SHALL check: FIFO full plus a continuous push stream with ready_in=1 for 10 cycles -> 10 packets are delivered in order and count stays constant.
REQ-041 SHALL check: flush with 3 packets queued and a push in the same cycle -> enable_out=0 from that cycle, empty=1 two cycles later, and no queued or flush-cycle packet ever appears.
REQ-042 SHALL check: rst=0 for one cycle during a stall with 2 packets queued -> outputs match REQ-032 on the next cycle and the next pushed packet is the first delivered.
REQ-043 SHALL check, with GIN_SOURCE_STATS_EN: 3 pops and 5 stall cycles -> pkt_sent=3, stall_cycles=5, and both unchanged after a flush.

Source files
------------

// File: rtl/gin_source.sv
// GIN packet source: queues {row_tag, col_tag, value} packets and issues them to the X/Y bus controllers.
// Optional statistics counters (pkt_sent, stall_cycles) are built when GIN_SOURCE_STATS_EN is defined.
module gin_source #(
    parameter int unsigned ID_LEN     = 4,
    parameter int unsigned VALUE_LEN  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ID_LEN-1:0]    in_row_tag,
    input  logic [ID_LEN-1:0]    in_col_tag,
    input  logic [VALUE_LEN-1:0] in_value,
    input  logic                 flush,
    output logic [ID_LEN-1:0]    row_tag,
    output logic [ID_LEN-1:0]    col_tag,
    output logic                 enable_out,
    output logic [VALUE_LEN-1:0] value_out,
    input  logic                 ready_in,
    output logic                 empty
`ifdef GIN_SOURCE_STATS_EN
    ,
    output logic [31:0]          pkt_sent,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * ID_LEN + VALUE_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [ID_LEN-1:0]    row_q;
    logic [ID_LEN-1:0]    col_q;
    logic [ID_LEN-1:0]    head_row;
    logic [ID_LEN-1:0]    head_col;
    logic [VALUE_LEN-1:0] head_value;
    logic                 full;
    logic                 push;
    logic                 pop;

    assign {head_row, head_col, head_value} = mem[rd_ptr];

    // Handshakes: in_ready never looks at ready_in, and flush masks the bus immediately.
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = ~full & ~flush & (state != DRAIN);
    assign enable_out = (state == ISSUE) & ~empty & ~flush;
    assign push       = in_valid & in_ready;
    assign pop        = enable_out & ready_in;

    // Bus outputs: head while enabled, otherwise zero payload and last tags.
    assign row_tag   = enable_out ? head_row : row_q;
    assign col_tag   = enable_out ? head_col : col_q;
    assign value_out = enable_out ? head_value : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (push || !empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pop && (count == CNT_W'(1)) && !push) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = DRAIN;
        end
    end

    // Pointer and occupancy bookkeeping; DRAIN wipes the queue in one edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            if (state == DRAIN) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
            if (enable_out) begin
                row_q <= head_row;
                col_q <= head_col;
            end
        end
    end

    // Packet storage carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_row_tag, in_col_tag, in_value};
        end
    end

`ifdef GIN_SOURCE_STATS_EN
    // Saturating statistics; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_sent     <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop && (pkt_sent != '1)) begin
                pkt_sent <= pkt_sent + 32'd1;
            end
            if (enable_out && !ready_in && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gin_source.sv
// Scoreboard bench for gin_source: accepted packets are queued and compared as they leave on the bus.
module tb_gin_source;

    typedef struct packed {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [31:0] value;
    } pkt_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_row_tag;
    logic [3:0]  in_col_tag;
    logic [31:0] in_value;
    logic        flush;
    logic [3:0]  row_tag;
    logic [3:0]  col_tag;
    logic        enable_out;
    logic [31:0] value_out;
    logic        ready_in;
    logic        empty;
`ifdef GIN_SOURCE_STATS_EN
    logic [31:0] pkt_sent;
    logic [31:0] stall_cycles;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;
    pkt_t sb[$];
    logic [3:0] hold_row = '0;
    logic [3:0] hold_col = '0;

    gin_source #(
        .ID_LEN    (4),
        .VALUE_LEN (32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row_tag  (in_row_tag),
        .in_col_tag  (in_col_tag),
        .in_value    (in_value),
        .flush       (flush),
        .row_tag     (row_tag),
        .col_tag     (col_tag),
        .enable_out  (enable_out),
        .value_out   (value_out),
        .ready_in    (ready_in),
        .empty       (empty)
`ifdef GIN_SOURCE_STATS_EN
        ,
        .pkt_sent    (pkt_sent),
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [3:0] r, input logic [3:0] c, input logic [31:0] v);
        pkt_t p;
        p.row   = r;
        p.col   = c;
        p.value = v;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input pkt_t p);
        in_valid   = 1'b1;
        in_row_tag = p.row;
        in_col_tag = p.col;
        in_value   = p.value;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (empty) break;
            step();
        end
        sample();
        check(tag, 64'(empty), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, 64'(enable_out), 64'(0));
        check({tag, "_value"}, 64'(value_out), 64'(0));
        check({tag, "_row"}, 64'(row_tag), 64'(0));
        check({tag, "_col"}, 64'(col_tag), 64'(0));
        check({tag, "_empty"}, 64'(empty), 64'(1));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    // Bus monitor: every enabled cycle must show the oldest outstanding packet.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            hold_row = '0;
            hold_col = '0;
        end else begin
            if (enable_out) begin
                if (sb.size() == 0) begin
                    check("enable_without_packet", 64'(enable_out), 64'(0));
                end else begin
                    check("bus_row", 64'(row_tag), 64'(sb[0].row));
                    check("bus_col", 64'(col_tag), 64'(sb[0].col));
                    check("bus_value", 64'(value_out), 64'(sb[0].value));
                    hold_row = sb[0].row;
                    hold_col = sb[0].col;
                    if (ready_in) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end else begin
                check("idle_value", 64'(value_out), 64'(0));
                check("idle_row_hold", 64'(row_tag), 64'(hold_row));
                check("idle_col_hold", 64'(col_tag), 64'(hold_col));
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(mk(in_row_tag, in_col_tag, in_value));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   s;
        logic acc;
        pkt_t p;

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_row_tag = '0;
        in_col_tag = '0;
        in_value   = '0;
        flush      = 1'b0;
        ready_in   = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        sample();
        check_reset_outputs("rst");

        // Single packet with ready_in high.
        step();
        ready_in = 1'b1;
        drive(mk(4'd2, 4'd5, 32'hDEAD_BEEF));
        sample();
        check("t1_pre_enable", 64'(enable_out), 64'(0));
        step();
        in_valid = 1'b0;
        sample();
        check("t1_enable", 64'(enable_out), 64'(1));
        check("t1_row", 64'(row_tag), 64'(2));
        check("t1_col", 64'(col_tag), 64'(5));
        check("t1_value", 64'(value_out), 64'(32'hDEAD_BEEF));
        step();
        sample();
        check("t1_enable_after", 64'(enable_out), 64'(0));
        check("t1_empty", 64'(empty), 64'(1));

        // Fill under stall, then drain back-to-back.
        step();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(4'(i), 4'(15 - i), 32'hA000_0000 + 32'(i)));
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t2_full_in_ready", 64'(in_ready), 64'(0));
            check("t2_stall_enable", 64'(enable_out), 64'(1));
            check("t2_stall_value", 64'(value_out), 64'(32'hA000_0000));
            step();
        end
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t2_drain_enable", 64'(enable_out), 64'(1));
            check("t2_drain_value", 64'(value_out), 64'(32'hA000_0000 + 32'(k)));
            step();
        end
        sample();
        check("t2_empty", 64'(empty), 64'(1));

        // Full FIFO with a continuous push stream.
        step();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(4'(8 + i), 4'(i), 32'hC000_0000 + 32'(i)));
            step();
        end
        base     = pops;
        ready_in = 1'b1;
        s        = 0;
        drive(mk(4'(s), 4'(s + 3), 32'h5000_0000 + 32'(s)));
        for (int k = 0; k < 10; k++) begin
            sample();
            check("t3_enable", 64'(enable_out), 64'(1));
            check("t3_in_ready", 64'(in_ready), (k == 0) ? 64'(0) : 64'(1));
            acc = in_ready;
            step();
            if (acc) s++;
            drive(mk(4'(s), 4'(s + 3), 32'h5000_0000 + 32'(s)));
        end
        in_valid = 1'b0;
        check("t3_pops", 64'(pops - base), 64'(10));
        wait_empty("t3_empty");

        // Flush with three packets queued and a push in the same cycle.
        step();
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(4'(i + 1), 4'(i + 9), 32'hF100_0000 + 32'(i)));
            step();
        end
        flush    = 1'b1;
        ready_in = 1'b1;
        drive(mk(4'hE, 4'hE, 32'hBAD0_BAD0));
        sample();
        check("t4_flush_enable", 64'(enable_out), 64'(0));
        check("t4_flush_in_ready", 64'(in_ready), 64'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sample();
        check("t4_drain_enable", 64'(enable_out), 64'(0));
        check("t4_drain_in_ready", 64'(in_ready), 64'(0));
        step();
        sample();
        check("t4_empty", 64'(empty), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check("t4_no_enable", 64'(enable_out), 64'(0));
            step();
            sample();
        end

        // Reset pulse during a stall with two packets queued.
        step();
        ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(mk(4'(i + 4), 4'(i + 6), 32'h7700_0000 + 32'(i)));
            step();
        end
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        sample();
        check_reset_outputs("t5");
        step();
        ready_in = 1'b1;
        p = mk(4'd9, 4'd3, 32'h1234_5678);
        drive(p);
        step();
        in_valid = 1'b0;
        sample();
        check("t5_first_enable", 64'(enable_out), 64'(1));
        check("t5_first_value", 64'(value_out), 64'(p.value));
        check("t5_first_row", 64'(row_tag), 64'(p.row));
        wait_empty("t5_empty");

`ifdef GIN_SOURCE_STATS_EN
        // Three pops and five stall cycles, then a flush that must not clear the counters.
        step();
        rst = 1'b0;
        step();
        rst      = 1'b1;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(4'(i), 4'(i), 32'h3300_0000 + 32'(i)));
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        ready_in = 1'b1;
        repeat (4) step();
        sample();
        check("stats_pkt_sent", 64'(pkt_sent), 64'(3));
        check("stats_stall_cycles", 64'(stall_cycles), 64'(5));
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        sample();
        check("stats_pkt_sent_flush", 64'(pkt_sent), 64'(3));
        check("stats_stall_cycles_flush", 64'(stall_cycles), 64'(5));
`endif

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
